dut_access_arbiter: RTL and testbench

Two-requester arbiter that shares the single write/read method pair of the 8-entry x 1-bit dut storage block. It accepts one command at a time from either requester using round-robin priority. It issues the command to the dut honouring write_rdy/read_rdy, then returns a one-cycle response (read data or write ack) to the owning requester. A stall watchdog aborts commands the dut never accepts.

---
 rtl/dut_access_arbiter_if.sv | 61 ++++++
 rtl/dut_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dut_access_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_access_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with its two requesters and
// with the 8x1 dut storage block. The master side is the environment (the
// requesters plus the dut); the slave side is the arbiter itself.
interface dut_access_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 1
);
    // Requester 0
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_data;
    logic              resp0_err;
    // Requester 1
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_data;
    logic              resp1_err;
    // dut write/read method pair
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;
    // Status
    logic              busy;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_data, resp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_data, resp1_err,
        input  write_address, write_data, write_en,
        output write_rdy,
        input  read_address, read_en,
        output read_data, read_rdy,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_data, resp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_data, resp1_err,
        output write_address, write_data, write_en,
        input  write_rdy,
        output read_address, read_en,
        input  read_data, read_rdy,
        output busy
    );
endinterface

// File: rtl/dut_access_arbiter.sv
// Round-robin arbiter giving two requesters shared access to the single
// write/read method pair of the dut storage block. One command is in flight
// at a time: accept (IDLE), hand it to the dut (ISSUE), return a one-cycle
// response to its owner (RESP). A stall watchdog aborts commands the dut
// never accepts.
module dut_access_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST_N,
    dut_access_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic              r_owner;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_stall;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    state_t            w_next_state;
    logic              w_winner;
    logic              w_accept;
    logic              w_rdy;
    logic              w_abort;
    logic              w_req0_ready;
    logic              w_req1_ready;
    logic              w_write_en;
    logic              w_read_en;
    logic              w_resp0_valid;
    logic              w_resp1_valid;
    logic [DATA_W-1:0] w_resp0_data;
    logic [DATA_W-1:0] w_resp1_data;
    logic              w_resp0_err;
    logic              w_resp1_err;

    // Tie-break toward the requester that was not granted last; a lone
    // requester always wins.
    assign w_winner = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                         : bus.req1_valid;
    assign w_rdy    = r_cmd_write ? bus.write_rdy : bus.read_rdy;
    assign w_abort  = (TIMEOUT != 0) && (r_stall == CNT_W'(TIMEOUT));

    // Next-state and output decode for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_req0_ready  = 1'b0;
        w_req1_ready  = 1'b0;
        w_write_en    = 1'b0;
        w_read_en     = 1'b0;
        w_resp0_valid = 1'b0;
        w_resp1_valid = 1'b0;
        w_resp0_data  = '0;
        w_resp1_data  = '0;
        w_resp0_err   = 1'b0;
        w_resp1_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // ready is combinational from valid, so it is also gated by
                // RST_N to keep every output low while reset is held.
                if (RST_N && (bus.req0_valid || bus.req1_valid)) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_winner;
                    w_req1_ready = w_winner;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The watchdog takes precedence: an aborted command never
                // reaches the dut, even if rdy rises in the abort cycle.
                if (w_abort) begin
                    w_next_state = S_RESP;
                end else if (w_rdy) begin
                    w_write_en   = r_cmd_write;
                    w_read_en    = ~r_cmd_write;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_resp0_valid = ~r_owner;
                w_resp1_valid = r_owner;
                w_resp0_data  = r_owner ? '0 : r_resp_data;
                w_resp1_data  = r_owner ? r_resp_data : '0;
                w_resp0_err   = ~r_owner & r_resp_err;
                w_resp1_err   = r_owner & r_resp_err;
                w_next_state  = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, command, stall-counter and response registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_cmd_write  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_stall      <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            r_state <= w_next_state;
            if (w_accept) begin
                r_cmd_write  <= w_winner ? bus.req1_write : bus.req0_write;
                r_cmd_addr   <= w_winner ? bus.req1_addr  : bus.req0_addr;
                r_cmd_wdata  <= w_winner ? bus.req1_wdata : bus.req0_wdata;
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_stall      <= '0;
            end
            if (r_state == S_ISSUE) begin
                if (w_abort) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                end else if (w_rdy) begin
                    r_resp_data <= r_cmd_write ? '0 : bus.read_data;
                    r_resp_err  <= 1'b0;
                end else begin
                    r_stall <= r_stall + CNT_W'(1);
                end
            end
        end
    end

    assign bus.req0_ready    = w_req0_ready;
    assign bus.req1_ready    = w_req1_ready;
    assign bus.resp0_valid   = w_resp0_valid;
    assign bus.resp1_valid   = w_resp1_valid;
    assign bus.resp0_data    = w_resp0_data;
    assign bus.resp1_data    = w_resp1_data;
    assign bus.resp0_err     = w_resp0_err;
    assign bus.resp1_err     = w_resp1_err;
    assign bus.write_en      = w_write_en;
    assign bus.read_en       = w_read_en;
    assign bus.write_address = r_cmd_addr;
    assign bus.write_data    = r_cmd_wdata;
    assign bus.read_address  = r_cmd_addr;
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_dut_access_arbiter.sv
// Testbench for dut_access_arbiter: directed stimulus, a transaction-level
// reference model compared on every cycle, and literal checks that pin the
// model on the key scenarios.
module tb_dut_access_arbiter;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 1;
    localparam int TIMEOUT = 15;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    dut_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dut_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              owner;
    } cmd_t;

    typedef struct {
        logic              owner;
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    cmd_t  m_cmd[$];   // command handed over, not yet taken by the dut
    resp_t m_resp[$];  // response owed on the next cycle
    int    m_stalled;  // dut-refused cycles of the current command
    logic  m_last = 1'b1;

    always @(negedge CLK) begin
        logic e_rdy0, e_rdy1, e_wen, e_ren, e_rv0, e_rv1, e_er0, e_er1, e_busy;
        logic [DATA_W-1:0] e_rd0, e_rd1;
        logic rdy, w;
        cmd_t c;
        resp_t r;
        e_rdy0 = 0; e_rdy1 = 0; e_wen = 0; e_ren = 0; e_rv0 = 0; e_rv1 = 0;
        e_er0 = 0; e_er1 = 0; e_busy = 0; e_rd0 = '0; e_rd1 = '0;
        if (!RST_N) begin
            m_cmd.delete();
            m_resp.delete();
            m_stalled = 0;
            m_last = 1'b1;
        end else if (m_resp.size() != 0) begin
            r = m_resp.pop_front();
            e_busy = 1;
            if (r.owner) begin e_rv1 = 1; e_rd1 = r.data; e_er1 = r.err; end
            else         begin e_rv0 = 1; e_rd0 = r.data; e_er0 = r.err; end
        end else if (m_cmd.size() != 0) begin
            c = m_cmd[0];
            e_busy = 1;
            rdy = c.write ? bus.write_rdy : bus.read_rdy;
            if (TIMEOUT != 0 && m_stalled == TIMEOUT) begin
                r.owner = c.owner; r.data = '0; r.err = 1'b1;
                m_resp.push_back(r);
                m_cmd.delete();
            end else if (rdy) begin
                r.owner = c.owner; r.err = 1'b0;
                r.data = c.write ? '0 : bus.read_data;
                m_resp.push_back(r);
                m_cmd.delete();
                if (c.write) begin
                    e_wen = 1;
                    check("write_address", 32'(bus.write_address), 32'(c.addr));
                    check("write_data", 32'(bus.write_data), 32'(c.wdata));
                end else begin
                    e_ren = 1;
                    check("read_address", 32'(bus.read_address), 32'(c.addr));
                end
            end else begin
                m_stalled++;
            end
        end else if (bus.req0_valid || bus.req1_valid) begin
            w = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
            c.owner = w;
            c.write = w ? bus.req1_write : bus.req0_write;
            c.addr  = w ? bus.req1_addr  : bus.req0_addr;
            c.wdata = w ? bus.req1_wdata : bus.req0_wdata;
            m_cmd.push_back(c);
            m_stalled = 0;
            m_last = w;
            if (w) e_rdy1 = 1; else e_rdy0 = 1;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(e_rdy0));
        check("req1_ready", 32'(bus.req1_ready), 32'(e_rdy1));
        check("write_en", 32'(bus.write_en), 32'(e_wen));
        check("read_en", 32'(bus.read_en), 32'(e_ren));
        check("resp0_valid", 32'(bus.resp0_valid), 32'(e_rv0));
        check("resp1_valid", 32'(bus.resp1_valid), 32'(e_rv1));
        check("resp0_data", 32'(bus.resp0_data), 32'(e_rd0));
        check("resp1_data", 32'(bus.resp1_data), 32'(e_rd1));
        check("resp0_err", 32'(bus.resp0_err), 32'(e_er0));
        check("resp1_err", 32'(bus.resp1_err), 32'(e_er1));
        check("busy", 32'(bus.busy), 32'(e_busy));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.write_rdy = 0; bus.read_rdy = 0; bus.read_data = '0;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d expected 0 pending", 1);
        $fatal(1, "time limit");
    end

    int  grants[$];
    int  wait_cyc;
    logic saw_wen;

    initial begin
        clear_inputs();
        #1 RST_N = 0;
        repeat (2) mid();
        cyc();
        RST_N = 1;
        cyc();

        // 1: req0 write addr 5 data 1
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 3'd5; bus.req0_wdata = 1'b1;
        bus.write_rdy = 1;
        mid(); check("t1 req0_ready@T", 32'(bus.req0_ready), 32'd1);
        cyc(); bus.req0_valid = 0;
        mid(); check("t1 write_en@T+1", 32'(bus.write_en), 32'd1);
        check("t1 write_address@T+1", 32'(bus.write_address), 32'd5);
        check("t1 write_data@T+1", 32'(bus.write_data), 32'd1);
        cyc();
        mid(); check("t1 resp0_valid@T+2", 32'(bus.resp0_valid), 32'd1);
        check("t1 resp0_data@T+2", 32'(bus.resp0_data), 32'd0);
        check("t1 resp0_err@T+2", 32'(bus.resp0_err), 32'd0);
        cyc(); clear_inputs();

        // 2: req1 read addr 5, dut returns 1
        bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 3'd5;
        bus.read_rdy = 1; bus.read_data = 1'b1;
        mid(); check("t2 req1_ready@T", 32'(bus.req1_ready), 32'd1);
        cyc(); bus.req1_valid = 0;
        mid(); check("t2 read_en@T+1", 32'(bus.read_en), 32'd1);
        check("t2 read_address@T+1", 32'(bus.read_address), 32'd5);
        cyc();
        mid(); check("t2 resp1_valid@T+2", 32'(bus.resp1_valid), 32'd1);
        check("t2 resp1_data@T+2", 32'(bus.resp1_data), 32'd1);
        check("t2 resp0_valid@T+2", 32'(bus.resp0_valid), 32'd0);
        cyc(); clear_inputs();

        // 3: both continuously valid from reset -> alternating grants
        RST_N = 0;
        mid();
        cyc(); RST_N = 1;
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 3'd2; bus.req0_wdata = 1'b1;
        bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 3'd6;
        bus.write_rdy = 1; bus.read_rdy = 1; bus.read_data = 1'b0;
        for (int i = 0; i < 18; i++) begin
            mid();
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            cyc();
            bus.read_data = ~bus.read_data;
        end
        clear_inputs();
        check("t3 grant count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check("t3 grant order", 32'(grants[i]), 32'(i % 2));
        cyc();

        // 4: req0 read stalled 4 cycles, accepted in the 5th
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 3'd3;
        mid(); check("t4 req0_ready", 32'(bus.req0_ready), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc(); bus.req0_valid = 0;
            bus.read_rdy = (i == 5); bus.read_data = 1'b1;
            mid();
            check("t4 read_en", 32'(bus.read_en), 32'(i == 5));
            check("t4 busy", 32'(bus.busy), 32'd1);
        end
        cyc(); clear_inputs();
        mid(); check("t4 resp0_valid", 32'(bus.resp0_valid), 32'd1);
        check("t4 resp0_err", 32'(bus.resp0_err), 32'd0);
        check("t4 resp0_data", 32'(bus.resp0_data), 32'd1);
        check("t4 busy", 32'(bus.busy), 32'd1);
        cyc();

        // 5: watchdog abort; rdy rises in the abort cycle but is ignored
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 3'd7; bus.req0_wdata = 1'b1;
        mid(); check("t5 req0_ready", 32'(bus.req0_ready), 32'd1);
        saw_wen = 0;
        wait_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(); bus.req0_valid = 0;
            bus.write_rdy = (i == 16);
            mid();
            if (bus.write_en) saw_wen = 1;
            if (bus.resp0_valid) begin
                wait_cyc = i;
                break;
            end
        end
        check("t5 cycles to abort resp", 32'(wait_cyc), 32'd17);
        check("t5 resp0_err", 32'(bus.resp0_err), 32'd1);
        check("t5 resp0_data", 32'(bus.resp0_data), 32'd0);
        check("t5 write_en never", 32'(saw_wen), 32'd0);
        cyc(); clear_inputs();
        bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 3'd1; bus.write_rdy = 1;
        mid(); check("t5 next req accepted", 32'(bus.req1_ready), 32'd1);
        cyc(); bus.req1_valid = 0;
        cyc(); cyc(); clear_inputs();

        // 6: async reset mid-ISSUE drops the command
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 3'd4;
        mid(); check("t6 req0_ready", 32'(bus.req0_ready), 32'd1);
        cyc();
        #2 RST_N = 0;
        #1 bus.read_rdy = 1;
        check("t6 busy in reset", 32'(bus.busy), 32'd0);
        check("t6 read_en in reset", 32'(bus.read_en), 32'd0);
        check("t6 write_en in reset", 32'(bus.write_en), 32'd0);
        check("t6 req0_ready in reset", 32'(bus.req0_ready), 32'd0);
        check("t6 resp0_valid in reset", 32'(bus.resp0_valid), 32'd0);
        check("t6 read_address in reset", 32'(bus.read_address), 32'd0);
        mid();
        cyc(); RST_N = 1;
        bus.read_rdy = 0;
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 3'd0;
        bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 3'd1;
        mid();
        check("t6 req0 first after reset", 32'(bus.req0_ready), 32'd1);
        check("t6 req1 waits after reset", 32'(bus.req1_ready), 32'd0);
        cyc(); bus.req0_valid = 0;
        check("t6 no stale resp", 32'(bus.resp0_valid), 32'd0);
        bus.write_rdy = 1; bus.read_rdy = 1;
        repeat (6) cyc();
        clear_inputs();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
